// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
//   Receive-side Hamming(12,8) single-error-correcting decoder. A codeword is
//   accepted over a valid/ready handshake. Its syndrome is accumulated one bit
//   position per cycle. A single-bit error is then corrected, and the 8 data
//   bits are presented with status flags over a second valid/ready handshake.
//   Saturating event counters track corrected and uncorrectable words for
//   link-health monitoring.
//
//   Code layout (bit p-1 of code_in holds Hamming position p, p = 1..12):
//     parity  : positions 1, 2, 4, 8 (even parity)
//     data    : d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   synchronous active-high reset
//   in_valid          in   codeword offered on code_in
//   in_ready          out  decoder idle and able to accept a codeword
//   code_in           in   12-bit codeword
//   out_valid         out  decoded result valid, held until taken
//   out_ready         in   downstream accepts the result
//   data_out          out  corrected data d7..d0
//   syndrome          out  syndrome computed for this word
//   err_corrected     out  syndrome 1..12, one bit flipped
//   err_uncorrectable out  syndrome 13..15
//   corr_count        out  saturating count of corrected words
//   uncorr_count      out  saturating count of uncorrectable words
// -----------------------------------------------------------------------------
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       data_out,
  output logic [3:0]       syndrome,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CORR = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q;
  logic [11:0]      code_q;
  logic [3:0]       pos_q;
  logic [3:0]       acc_q;
  logic [3:0]       acc_d;
  logic             out_valid_q;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic [3:0]       syn_q;
  logic             err_c_q;
  logic             err_u_q;
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_q;
  logic             correctable;
  logic             uncorrectable;
  logic [11:0]      fixed_code;

  // Syndrome step: fold the current position index in when its bit is set.
  // pos_q only ranges 1..12 while scanning, so pos_q-1 stays inside code_q.
  always_comb begin
    acc_d = acc_q;
    if (code_q[pos_q - 4'd1]) begin
      acc_d = acc_q ^ pos_q;
    end
  end

  assign correctable   = (acc_q != 4'd0) && (acc_q <= 4'd12);
  assign uncorrectable = (acc_q >= 4'd13);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fixed_code = code_q;
    if (correctable) begin
      fixed_code[acc_q - 4'd1] = ~code_q[acc_q - 4'd1];
    end
    data_d = {fixed_code[11], fixed_code[10], fixed_code[9], fixed_code[8],
              fixed_code[6],  fixed_code[5],  fixed_code[4], fixed_code[2]};
  end

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      pos_q        <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      syn_q        <= '0;
      err_c_q      <= 1'b0;
      err_u_q      <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            code_q  <= code_in;
            acc_q   <= '0;
            pos_q   <= 4'd1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc_q <= acc_d;
          pos_q <= pos_q + 4'd1;
          if (pos_q == 4'd12) begin
            state_q <= ST_CORR;
          end
        end
        ST_CORR: begin
          data_q      <= data_d;
          syn_q       <= acc_q;
          err_c_q     <= correctable;
          err_u_q     <= uncorrectable;
          out_valid_q <= 1'b1;
          if (correctable && (corr_cnt_q != CNT_MAX)) begin
            corr_cnt_q <= corr_cnt_q + CNT_W'(1);
          end
          if (uncorrectable && (uncorr_cnt_q != CNT_MAX)) begin
            uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
          end
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          // Result registers are left untouched here, so they stay stable
          // under backpressure until the handshake completes.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready          = (state_q == ST_IDLE);
  assign out_valid         = out_valid_q;
  assign data_out          = data_q;
  assign syndrome          = syn_q;
  assign err_corrected     = err_c_q;
  assign err_uncorrectable = err_u_q;
  assign corr_count        = corr_cnt_q;
  assign uncorr_count      = uncorr_cnt_q;

endmodule
